// File: rtl/usb_rx_bit_sequencer_if.sv
// Bus between the USB receive bit sequencer and its environment.
// slave  : the sequencer (takes line/enable, drives strobes and status).
// master : the driver side (drives line/enable, observes strobes and status).
// Signals: enable, d_plus, d_minus (to sequencer); shift_enable, serial_bit,
//          byte_done, eop, rx_err, busy (from sequencer).
interface usb_rx_bit_sequencer_if;
   logic enable;
   logic d_plus;
   logic d_minus;
   logic shift_enable;
   logic serial_bit;
   logic byte_done;
   logic eop;
   logic rx_err;
   logic busy;

   modport slave (
      input  enable, d_plus, d_minus,
      output shift_enable, serial_bit, byte_done, eop, rx_err, busy
   );

   modport master (
      output enable, d_plus, d_minus,
      input  shift_enable, serial_bit, byte_done, eop, rx_err, busy
   );
endinterface

// File: rtl/usb_rx_bit_sequencer.sv
// USB 1.1 full-speed receive bit sequencer: recovers bit timing from the
// synchronized D+/D- pair, NRZI-decodes, removes stuffed bits and strobes
// decoded bits into an LSB-first 8-bit shift register. Reports byte
// boundaries, end-of-packet and receive errors.
// Ports: clk, n_rst (async active-low), bus (slave modport):
//   enable, d_plus, d_minus in; shift_enable, serial_bit, byte_done, eop,
//   rx_err, busy out (all registered).
module usb_rx_bit_sequencer #(
   parameter int unsigned CLKS_PER_BIT = 8,
   parameter int unsigned SAMPLE_POINT = 3
) (
   input logic                     clk,
   input logic                     n_rst,
   usb_rx_bit_sequencer_if.slave   bus
);

   localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);

   typedef enum logic [1:0] {IDLE, RECEIVE, SE0_1, ABORT} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             dp_last_q;
   logic             prev_sample_q, prev_sample_d;
   logic [2:0]       ones_cnt_q, ones_cnt_d;
   logic [2:0]       bit_cnt_q, bit_cnt_d;
   logic             byte_pend_q, byte_pend_d;
   logic             shift_q, shift_d;
   logic             sbit_q, sbit_d;
   logic             byte_done_q, byte_done_d;
   logic             eop_q, eop_d;
   logic             err_q, err_d;
   logic             busy_q;

   logic dp_edge_c, se0_c, line_j_c, sample_c, decoded_c;

   assign dp_edge_c = (bus.d_plus != dp_last_q);
   assign se0_c     = !bus.d_plus && !bus.d_minus;
   assign line_j_c  =  bus.d_plus && !bus.d_minus;
   assign sample_c  = (state_q != IDLE) && (cnt_q == CNT_W'(SAMPLE_POINT));
   assign decoded_c = (bus.d_plus == prev_sample_q);

   // State and datapath registers
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         dp_last_q     <= 1'b1;
         prev_sample_q <= 1'b1;
         ones_cnt_q    <= '0;
         bit_cnt_q     <= '0;
         byte_pend_q   <= 1'b0;
         shift_q       <= 1'b0;
         sbit_q        <= 1'b0;
         byte_done_q   <= 1'b0;
         eop_q         <= 1'b0;
         err_q         <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         dp_last_q     <= bus.d_plus;
         prev_sample_q <= prev_sample_d;
         ones_cnt_q    <= ones_cnt_d;
         bit_cnt_q     <= bit_cnt_d;
         byte_pend_q   <= byte_pend_d;
         shift_q       <= shift_d;
         sbit_q        <= sbit_d;
         byte_done_q   <= byte_done_d;
         eop_q         <= eop_d;
         err_q         <= err_d;
         busy_q        <= (state_d != IDLE);
      end
   end

   // Next-state, counters and strobe generation
   always_comb begin
      state_d       = state_q;
      prev_sample_d = prev_sample_q;
      ones_cnt_d    = ones_cnt_q;
      bit_cnt_d     = bit_cnt_q;
      byte_pend_d   = 1'b0;
      shift_d       = 1'b0;
      sbit_d        = 1'b0;
      byte_done_d   = byte_pend_q;
      eop_d         = 1'b0;
      err_d         = 1'b0;

      // Bit timing: resync on every D+ transition, otherwise free-run
      if (state_q == IDLE || dp_edge_c)
         cnt_d = '0;
      else if (cnt_q == CNT_W'(CLKS_PER_BIT - 1))
         cnt_d = '0;
      else
         cnt_d = cnt_q + CNT_W'(1);

      case (state_q)
         IDLE: begin
            // J->K transition marks the start of SYNC
            if (dp_last_q && !bus.d_plus && bus.d_minus) begin
               state_d       = RECEIVE;
               prev_sample_d = 1'b1;
               ones_cnt_d    = '0;
               bit_cnt_d     = '0;
            end
         end
         RECEIVE: begin
            if (sample_c) begin
               if (se0_c) begin
                  state_d = SE0_1;
               end else begin
                  prev_sample_d = bus.d_plus;
                  if (ones_cnt_q == 3'd6) begin
                     if (decoded_c) begin
                        err_d   = 1'b1;
                        state_d = ABORT;
                     end else begin
                        ones_cnt_d = '0;
                     end
                  end else begin
                     shift_d    = 1'b1;
                     sbit_d     = decoded_c;
                     ones_cnt_d = decoded_c ? ones_cnt_q + 3'd1 : 3'd0;
                     bit_cnt_d  = bit_cnt_q + 3'd1;
                     byte_pend_d = (bit_cnt_q == 3'd7);
                  end
               end
            end
         end
         SE0_1: begin
            if (sample_c) begin
               if (se0_c) begin
                  eop_d   = 1'b1;
                  err_d   = (bit_cnt_q != 3'd0);
                  state_d = IDLE;
               end else begin
                  err_d   = 1'b1;
                  state_d = ABORT;
               end
            end
         end
         ABORT: begin
            if (sample_c && line_j_c) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Disarm wins over everything and suppresses all strobes
      if (!bus.enable) begin
         state_d     = IDLE;
         cnt_d       = '0;
         byte_pend_d = 1'b0;
         shift_d     = 1'b0;
         sbit_d      = 1'b0;
         byte_done_d = 1'b0;
         eop_d       = 1'b0;
         err_d       = 1'b0;
      end
   end

   assign bus.shift_enable = shift_q;
   assign bus.serial_bit   = sbit_q;
   assign bus.byte_done    = byte_done_q;
   assign bus.eop          = eop_q;
   assign bus.rx_err       = err_q;
   assign bus.busy         = busy_q;

endmodule
